// File: rtl/e_mdu.sv
// Execute-stage multiply/divide unit holding the HI/LO registers; results commit after a fixed busy window.
// Optional macro MDU_CANCEL_EN adds a `cancel` input that flushes an in-flight or launching operation.
module e_mdu #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  md_op,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
`ifdef MDU_CANCEL_EN
  input  logic        cancel,
`endif
  output logic        busy,
  output logic [31:0] hi_out,
  output logic [31:0] lo_out
);

  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;
  localparam logic [3:0] MC = 4'(MULT_CYCLES);
  localparam logic [3:0] DC = 4'(DIV_CYCLES);

  typedef enum logic {IDLE, RUN} state_t;

  state_t      state, state_nx;
  logic [3:0]  cnt, cnt_nx;
  logic [31:0] phi, phi_nx, plo, plo_nx, hi_nx, lo_nx;
  logic        kill;

`ifdef MDU_CANCEL_EN
  assign kill = cancel;
`else
  assign kill = 1'b0;
`endif

  // Sign-extending to 64 bits makes the low 64 bits of the product the signed result.
  logic [63:0] prod_s, prod_u;
  assign prod_s = {{32{rs_data[31]}}, rs_data} * {{32{rt_data[31]}}, rt_data};
  assign prod_u = {32'd0, rs_data} * {32'd0, rt_data};

  // Signed divide via magnitudes so 0x80000000 / -1 wraps to 0x80000000 with remainder 0.
  logic        sgn;
  logic [31:0] a_mag, b_mag, b_safe, q_mag, r_mag, quo, rem;
  always_comb begin
    sgn    = (md_op == OP_DIV);
    a_mag  = (sgn && rs_data[31]) ? (32'd0 - rs_data) : rs_data;
    b_mag  = (sgn && rt_data[31]) ? (32'd0 - rt_data) : rt_data;
    b_safe = (b_mag == 32'd0) ? 32'd1 : b_mag;
    q_mag  = a_mag / b_safe;
    r_mag  = a_mag % b_safe;
    quo    = (sgn && (rs_data[31] ^ rt_data[31])) ? (32'd0 - q_mag) : q_mag;
    rem    = (sgn && rs_data[31]) ? (32'd0 - r_mag) : r_mag;
    if (rt_data == 32'd0) begin
      quo = 32'hFFFF_FFFF;
      rem = rs_data;
    end
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    phi_nx   = phi;
    plo_nx   = plo;
    hi_nx    = hi_out;
    lo_nx    = lo_out;
    case (state)
      IDLE: begin
        if (start && !kill) begin
          case (md_op)
            OP_MULT, OP_MULTU: begin
              {phi_nx, plo_nx} = (md_op == OP_MULT) ? prod_s : prod_u;
              cnt_nx   = MC;
              state_nx = RUN;
            end
            OP_DIV, OP_DIVU: begin
              phi_nx   = rem;
              plo_nx   = quo;
              cnt_nx   = DC;
              state_nx = RUN;
            end
            OP_MTHI: hi_nx = rs_data;
            OP_MTLO: lo_nx = rs_data;
            default: ;
          endcase
        end
      end
      RUN: begin
        if (kill) begin
          state_nx = IDLE;
          cnt_nx   = 4'd0;
          phi_nx   = 32'd0;
          plo_nx   = 32'd0;
        end else if (cnt == 4'd1) begin
          hi_nx    = phi;
          lo_nx    = plo;
          state_nx = IDLE;
          cnt_nx   = 4'd0;
        end else begin
          cnt_nx = cnt - 4'd1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      cnt    <= 4'd0;
      phi    <= 32'd0;
      plo    <= 32'd0;
      hi_out <= 32'd0;
      lo_out <= 32'd0;
    end else begin
      state  <= state_nx;
      cnt    <= cnt_nx;
      phi    <= phi_nx;
      plo    <= plo_nx;
      hi_out <= hi_nx;
      lo_out <= lo_nx;
    end
  end

  assign busy = (state == RUN);

endmodule

// File: tb/tb_e_mdu.sv
// Directed testbench for e_mdu: multiply, divide, moves, ignored starts, async reset and optional cancel.
module tb_e_mdu;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  md_op = 3'd0;
  logic [31:0] rs_data = 32'd0, rt_data = 32'd0;
  logic        busy;
  logic [31:0] hi_out, lo_out;
`ifdef MDU_CANCEL_EN
  logic        cancel = 1'b0;
`endif

  int n_run = 0, n_fail = 0;

  e_mdu #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset(reset), .start(start), .md_op(md_op),
    .rs_data(rs_data), .rt_data(rt_data),
`ifdef MDU_CANCEL_EN
    .cancel(cancel),
`endif
    .busy(busy), .hi_out(hi_out), .lo_out(lo_out)
  );

  always #5 clk = ~clk;

  task automatic launch(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    @(posedge clk); #1;
    start = 1'b1; md_op = op; rs_data = a; rt_data = b;
    @(posedge clk); #1;
    start = 1'b0; md_op = 3'd0;
  endtask

  // Counts busy samples after launch and notes whether HI/LO ever moved while busy.
  task automatic wait_done(input logic [31:0] h0, input logic [31:0] l0, output int cyc, output bit held);
    cyc = 0; held = 1'b1;
    while (busy === 1'b1 && cyc < 40) begin
      if (hi_out !== h0 || lo_out !== l0) held = 1'b0;
      cyc++;
      @(posedge clk); #1;
    end
  endtask

  task automatic run_check(input string name, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                           input int exp_cyc, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    logic [31:0] h0, l0;
    int cyc; bit held;
    h0 = hi_out; l0 = lo_out;
    launch(op, a, b);
    wait_done(h0, l0, cyc, held);
    n_run++; if (cyc != exp_cyc) begin n_fail++; $display("FAIL %s busy_cycles got %0d exp %0d", name, cyc, exp_cyc); end
    n_run++; if (!held) begin n_fail++; $display("FAIL %s hilo_hold got changed exp held", name); end
    n_run++; if (hi_out !== exp_hi) begin n_fail++; $display("FAIL %s hi got %h exp %h", name, hi_out, exp_hi); end
    n_run++; if (lo_out !== exp_lo) begin n_fail++; $display("FAIL %s lo got %h exp %h", name, lo_out, exp_lo); end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    #12;
    n_run++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b exp 0", busy); end
    n_run++; if (hi_out !== 32'd0) begin n_fail++; $display("FAIL reset_hi got %h exp 0", hi_out); end
    n_run++; if (lo_out !== 32'd0) begin n_fail++; $display("FAIL reset_lo got %h exp 0", lo_out); end
    @(negedge clk); reset = 1'b1;
  endtask

  task automatic test_mult();
    run_check("mult", 3'd1, 32'hFFFF_FFFE, 32'd3, 5, 32'hFFFF_FFFF, 32'hFFFF_FFFA);
    run_check("multu", 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5, 32'hFFFF_FFFE, 32'h0000_0001);
  endtask

  task automatic test_div();
    run_check("div_neg", 3'd3, 32'hFFFF_FFF9, 32'd2, 10, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_check("div_negdivisor", 3'd3, 32'd7, 32'hFFFF_FFFE, 10, 32'd1, 32'hFFFF_FFFD);
    run_check("divu_zero", 3'd4, 32'h1234, 32'd0, 10, 32'h1234, 32'hFFFF_FFFF);
    run_check("div_zero", 3'd3, 32'hFFFF_FFF0, 32'd0, 10, 32'hFFFF_FFF0, 32'hFFFF_FFFF);
    run_check("div_ovf", 3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 10, 32'd0, 32'h8000_0000);
    run_check("divu", 3'd4, 32'd100, 32'd7, 10, 32'd2, 32'd14);
  endtask

  task automatic test_moves();
    int cnt_busy = 0;
    @(posedge clk); #1;
    start = 1'b1; md_op = 3'd5; rs_data = 32'hDEAD_BEEF;
    @(posedge clk); #1;
    if (busy) cnt_busy++;
    n_run++; if (hi_out !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL mthi got %h exp deadbeef", hi_out); end
    md_op = 3'd6; rs_data = 32'hCAFE_F00D;
    @(posedge clk); #1;
    if (busy) cnt_busy++;
    start = 1'b0; md_op = 3'd0;
    n_run++; if (lo_out !== 32'hCAFE_F00D) begin n_fail++; $display("FAIL mtlo got %h exp cafef00d", lo_out); end
    n_run++; if (hi_out !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL mtlo_hi got %h exp deadbeef", hi_out); end
    // NONE and reserved opcodes must leave everything alone.
    start = 1'b1; md_op = 3'd0; rs_data = 32'h1111_1111; rt_data = 32'd2;
    @(posedge clk); #1;
    if (busy) cnt_busy++;
    md_op = 3'd7;
    @(posedge clk); #1;
    if (busy) cnt_busy++;
    start = 1'b0; md_op = 3'd0;
    n_run++; if (cnt_busy != 0) begin n_fail++; $display("FAIL moves_busy got %0d exp 0", cnt_busy); end
    n_run++; if (hi_out !== 32'hDEAD_BEEF || lo_out !== 32'hCAFE_F00D)
      begin n_fail++; $display("FAIL nop_hilo got %h/%h exp deadbeef/cafef00d", hi_out, lo_out); end
  endtask

  task automatic test_back_to_back();
    int cyc; bit held;
    launch(3'd1, 32'd5, 32'd6);
    start = 1'b1; md_op = 3'd3; rs_data = 32'd100; rt_data = 32'd7;
    @(posedge clk); #1;
    start = 1'b0; md_op = 3'd0;
    wait_done(32'hDEAD_BEEF, 32'hCAFE_F00D, cyc, held);
    n_run++; if (cyc != 4) begin n_fail++; $display("FAIL b2b_busy got %0d exp 4", cyc); end
    n_run++; if (hi_out !== 32'd0 || lo_out !== 32'd30)
      begin n_fail++; $display("FAIL b2b_result got %h/%h exp 0/1e", hi_out, lo_out); end
    repeat (12) @(posedge clk); #1;
    n_run++; if (busy !== 1'b0 || lo_out !== 32'd30)
      begin n_fail++; $display("FAIL b2b_idle got busy %b lo %h exp 0/1e", busy, lo_out); end
  endtask

  task automatic test_async_reset();
    launch(3'd3, 32'd1000, 32'd3);
    @(posedge clk); #1;
    @(posedge clk); #1;
    n_run++; if (busy !== 1'b1) begin n_fail++; $display("FAIL arst_pre_busy got %b exp 1", busy); end
    #2 reset = 1'b0;
    #1;
    n_run++; if (busy !== 1'b0 || hi_out !== 32'd0 || lo_out !== 32'd0)
      begin n_fail++; $display("FAIL arst_now got %b %h %h exp 0 0 0", busy, hi_out, lo_out); end
    @(negedge clk); reset = 1'b1;
    repeat (12) @(posedge clk); #1;
    n_run++; if (busy !== 1'b0 || hi_out !== 32'd0 || lo_out !== 32'd0)
      begin n_fail++; $display("FAIL arst_after got %b %h %h exp 0 0 0", busy, hi_out, lo_out); end
    run_check("post_rst_mult", 3'd1, 32'd5, 32'd6, 5, 32'd0, 32'd30);
  endtask

`ifdef MDU_CANCEL_EN
  task automatic test_cancel();
    @(posedge clk); #1;
    start = 1'b1; md_op = 3'd5; rs_data = 32'h11;
    @(posedge clk); #1;
    md_op = 3'd6; rs_data = 32'h22;
    @(posedge clk); #1;
    start = 1'b0; md_op = 3'd0;
    launch(3'd1, 32'd5, 32'd6);
    @(posedge clk); #1;
    cancel = 1'b1;
    @(posedge clk); #1;
    cancel = 1'b0;
    n_run++; if (busy !== 1'b0) begin n_fail++; $display("FAIL cancel_busy got %b exp 0", busy); end
    repeat (8) @(posedge clk); #1;
    n_run++; if (hi_out !== 32'h11 || lo_out !== 32'h22)
      begin n_fail++; $display("FAIL cancel_hilo got %h/%h exp 11/22", hi_out, lo_out); end
    start = 1'b1; cancel = 1'b1; md_op = 3'd5; rs_data = 32'h99;
    @(posedge clk); #1;
    md_op = 3'd3; rs_data = 32'd9; rt_data = 32'd2;
    @(posedge clk); #1;
    start = 1'b0; cancel = 1'b0; md_op = 3'd0;
    n_run++; if (busy !== 1'b0 || hi_out !== 32'h11 || lo_out !== 32'h22)
      begin n_fail++; $display("FAIL cancel_start got %b %h %h exp 0 11 22", busy, hi_out, lo_out); end
  endtask
`endif

  initial begin
    test_reset();
    test_mult();
    test_div();
    test_moves();
    test_back_to_back();
    test_async_reset();
`ifdef MDU_CANCEL_EN
    test_cancel();
`endif
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule

// File: doc/e_mdu.md
Name: e_mdu

Overview:
- Multiply/divide unit in the execute stage, directly downstream of the D->E pipeline register.
- Consumes the latched instruction's decoded MD operation and its rs/rt operands.
- Runs multi-cycle signed/unsigned multiply and divide, and holds the HI/LO architectural registers.
- Drives `busy` so hazard logic stalls later MD instructions in decode.

Parameters:
- MULT_CYCLES, 5, busy duration for MULT/MULTU (valid 1..15)
- DIV_CYCLES, 10, busy duration for DIV/DIVU (valid 1..15)

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low reset (0 = in reset)
- start  input  1  MD instruction valid in E this cycle (already gated by stall/flush upstream)
- md_op  input  3  0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 reserved (treated as NONE)
- rs_data  input  32  operand A (dividend / multiplicand / MTHI/MTLO source)
- rt_data  input  32  operand B (divisor / multiplier)
- busy  output  1  operation in flight
- hi_out  output  32  HI register
- lo_out  output  32  LO register

Behaviour:
- Reset (reset=0, asynchronous):
  - hi_out=0, lo_out=0, busy=0, counter=0, pending regs=0, state IDLE.
  - Asserting reset mid-operation aborts the op; no result is committed.
- States:
  - IDLE: busy=0.
  - RUN: busy=1, 4-bit down-counter active.
- IDLE, start=1, md_op MULT/MULTU:
  - Compute the 64-bit product at the edge and store it in pending_hi/pending_lo.
  - counter<=MULT_CYCLES; go to RUN.
  - MULT: signed 32x32. MULTU: unsigned.
- IDLE, start=1, md_op DIV/DIVU:
  - pending_lo=quotient, pending_hi=remainder; counter<=DIV_CYCLES; go to RUN.
  - Signed: quotient truncates toward zero; remainder takes the dividend's sign.
  - Divisor 0: pending_hi=rs_data, pending_lo=32'hFFFFFFFF, full busy duration.
  - DIV 0x80000000 / 0xFFFFFFFF: quotient 0x80000000, remainder 0.
- IDLE, start=1, MTHI/MTLO:
  - hi_out (or lo_out)<=rs_data at that edge; busy stays 0; no RUN.
- RUN:
  - Each edge: counter<=counter-1.
  - On the edge where counter==1: hi_out<=pending_hi, lo_out<=pending_lo, busy<=0, go to IDLE.
  - busy is high for exactly N cycles, starting the cycle after start.
  - HI/LO hold their old values throughout RUN and change on the same edge that busy falls.
- start=1 while in RUN: ignored; upstream must stall MD instructions while start|busy.
- start=1 with md_op NONE/7: no effect.
- Reads: hi_out/lo_out are plain register outputs; E-stage MFHI/MFLO read them combinationally.

Optional Feature:
- Macro: MDU_CANCEL_EN.
- Defined:
  - Adds port `cancel` (input, 1).
  - cancel=1 in RUN: go to IDLE at the next edge, busy=0, HI/LO unchanged, pending discarded.
  - cancel=1 in the same cycle as start (IDLE): the op is not launched, and MTHI/MTLO do not write.
  - Used for exception/interrupt flush.
- Undefined: no `cancel` port; every launched operation runs to completion.

Test Plan:
- MULT: rs=0xFFFFFFFE (-2), rt=3, start 1 cycle -> busy=1 for 5 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFFA, busy=0 on the same edge.
- MULTU: rs=0xFFFFFFFF, rt=0xFFFFFFFF -> after 5 cycles hi=0xFFFFFFFE, lo=0x00000001.
- DIV: rs=-7 (0xFFFFFFF9), rt=2 -> busy for 10 cycles, then lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU with rt=0, rs=0x1234 -> lo=0xFFFFFFFF, hi=0x1234.
- MTHI rs=0xDEADBEEF -> hi=0xDEADBEEF next edge, busy never asserts. Start a MULT, issue a second start during RUN -> second start ignored, first result committed.
- Pull reset low at the 3rd busy cycle of a DIV -> busy, hi, lo read 0 immediately (asynchronous); after release, state IDLE.
- With MDU_CANCEL_EN: MULT 5x6, cancel at 2nd busy cycle -> busy=0 next edge, hi/lo keep their prior values (not 0/30).
